// File: rtl/usb_pkg.sv
//----------------------------------------------------------------------------
// usb_pkg : class codes, switch FSM encoding and request helper shared by
//           the USB top, its mux/status logic and the class switch sequencer
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

package usb_pkg;

  localparam logic [2:0] CLASS_NONE     = 3'd0;
  localparam logic [2:0] CLASS_AUDIO    = 3'd1;
  localparam logic [2:0] CLASS_CAMERA   = 3'd2;
  localparam logic [2:0] CLASS_DISK     = 3'd3;
  localparam logic [2:0] CLASS_KEYBOARD = 3'd4;
  localparam logic [2:0] CLASS_SERIAL   = 3'd5;

  typedef enum logic [1:0] {
    SW_OFF        = 2'd0,
    SW_DISCONNECT = 2'd1,
    SW_SETTLE     = 2'd2,
    SW_ACTIVE     = 2'd3
  } sw_state_e;

  // Out-of-range CCR codes select the highest implemented class.
  function automatic logic [2:0] sat_class(input logic [2:0] req,
                                           input logic [2:0] max_cls);
    return (req > max_cls) ? max_cls : req;
  endfunction

endpackage

`default_nettype wire

// File: rtl/usb_sw_timer.sv
//----------------------------------------------------------------------------
// usb_sw_timer : loadable down-counter with enable and zero flag; stops at 0
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module usb_sw_timer #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

`default_nettype wire

// File: rtl/usb_class_switch_ctrl.sv
//----------------------------------------------------------------------------
// usb_class_switch_ctrl : forces a timed bus detach on every class change,
//   then releases and settles only the newly selected core.
//   Optional sticky completion interrupt: define USB_CLASS_SWITCH_IRQ_EN.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module usb_class_switch_ctrl
  import usb_pkg::*;
#(
  parameter int NUM_CLASSES   = 5,
  parameter int DISC_CYCLES   = 6000000,
  parameter int SETTLE_CYCLES = 64,
  parameter int CNT_W         = 24
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [2:0]             class_req_i,
  input  logic                   core_pull_i,
  output logic [NUM_CLASSES-1:0] core_rstn_o,
  output logic [2:0]             active_class_o,
  output logic                   usb_dp_pull_o,
  output logic                   phy_oe_en_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   irq_o,
  input  logic                   irq_clr_i
);

  localparam logic [2:0]       MAX_CLASS   = 3'(NUM_CLASSES);
  localparam logic [CNT_W-1:0] DISC_LOAD   = CNT_W'(DISC_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  logic [2:0]       req_q;
  logic [2:0]       target;
  sw_state_e        state;
  logic             done;
  logic             req_change;
  logic             released;
  logic             cnt_load;
  logic             cnt_en;
  logic             cnt_zero;
  logic [CNT_W-1:0] cnt_load_val;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_q <= CLASS_NONE;
    end else begin
      req_q <= sat_class(class_req_i, MAX_CLASS);
    end
  end

  assign req_change   = (req_q != target);
  assign cnt_load     = req_change ||
                        ((state == SW_DISCONNECT) && cnt_zero && (target != CLASS_NONE));
  assign cnt_load_val = req_change ? DISC_LOAD : SETTLE_LOAD;
  assign cnt_en       = (state == SW_DISCONNECT) || (state == SW_SETTLE);

  usb_sw_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk      (clk_i),
    .rst      (rst_i),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

  // A new request pre-empts everything, so aborted switches never pulse done.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= SW_OFF;
      target <= CLASS_NONE;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (req_change) begin
        target <= req_q;
        state  <= SW_DISCONNECT;
      end else begin
        case (state)
          SW_DISCONNECT: begin
            if (cnt_zero) begin
              if (target == CLASS_NONE) begin
                state <= SW_OFF;
                done  <= 1'b1;
              end else begin
                state <= SW_SETTLE;
              end
            end
          end
          SW_SETTLE: begin
            if (cnt_zero) begin
              state <= SW_ACTIVE;
              done  <= 1'b1;
            end
          end
          default: state <= state;
        endcase
      end
    end
  end

  assign released = (state == SW_SETTLE) || (state == SW_ACTIVE);

  always_comb begin
    core_rstn_o = '0;
    for (int k = 0; k < NUM_CLASSES; k++) begin
      core_rstn_o[k] = released && (target == 3'(k + 1));
    end
  end

  assign active_class_o = released ? target : CLASS_NONE;
  assign usb_dp_pull_o  = (state == SW_ACTIVE) && core_pull_i;
  assign phy_oe_en_o    = released;
  assign busy_o         = (state == SW_DISCONNECT) || (state == SW_SETTLE);
  assign done_o         = done;

`ifdef USB_CLASS_SWITCH_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_q <= 1'b0;
    end else if (done) begin
      irq_q <= 1'b1;
    end else if (irq_clr_i) begin
      irq_q <= 1'b0;
    end
  end

  assign irq_o = irq_q;
`else
  logic unused_irq_clr;

  assign unused_irq_clr = irq_clr_i;
  assign irq_o          = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_usb_class_switch_ctrl.sv
//----------------------------------------------------------------------------
// tb_usb_class_switch_ctrl : vector table, corner sequences and random
//   traffic against a timeline model of the class switch sequencer
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_usb_class_switch_ctrl;

  localparam int D   = 8;
  localparam int S   = 3;
  localparam int CAP = 1000;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] class_req;
  logic       core_pull;
  logic       irq_clr;
  logic [4:0] core_rstn;
  logic [2:0] active_class;
  logic       dp_pull;
  logic       oe_en;
  logic       busy;
  logic       done;
  logic       irq;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  // Model: target plus cycles elapsed since the current switch started.
  logic [2:0] m_reqq = 3'd0;
  logic [2:0] m_tgt  = 3'd0;
  int         m_e    = CAP;
  bit         m_done = 1'b0;
  bit         m_irq  = 1'b0;

  always #5 clk = ~clk;

  usb_class_switch_ctrl #(
    .NUM_CLASSES   (5),
    .DISC_CYCLES   (D),
    .SETTLE_CYCLES (S),
    .CNT_W         (24)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .class_req_i    (class_req),
    .core_pull_i    (core_pull),
    .core_rstn_o    (core_rstn),
    .active_class_o (active_class),
    .usb_dp_pull_o  (dp_pull),
    .phy_oe_en_o    (oe_en),
    .busy_o         (busy),
    .done_o         (done),
    .irq_o          (irq),
    .irq_clr_i      (irq_clr)
  );

  typedef struct {
    logic       rst;
    logic [2:0] req;
    logic       pull;
    logic       clr;
    int         hold;
    logic [11:0] exp; // {rstn, active, pull, oe, busy, done}
  } vec_t;

  function automatic logic [12:0] act_vec();
    return {core_rstn, active_class, dp_pull, oe_en, busy, done, irq};
  endfunction

  function automatic logic [12:0] model_vec();
    int         ph;
    bit         rel;
    logic [4:0] one;
    logic [4:0] rstn;
    bit         irq_e;
    one = 5'b00001;
    if (m_tgt == 3'd0)   ph = (m_e < D) ? 1 : 0;
    else if (m_e < D)     ph = 1;
    else if (m_e < D + S) ph = 2;
    else                  ph = 3;
    rel  = (ph >= 2);
    rstn = rel ? (one << (int'(m_tgt) - 1)) : 5'b0;
`ifdef USB_CLASS_SWITCH_IRQ_EN
    irq_e = m_irq;
`else
    irq_e = 1'b0;
`endif
    return {rstn, rel ? m_tgt : 3'd0, (ph == 3) && core_pull, rel,
            (ph == 1) || (ph == 2), m_done, irq_e};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model on the edge, then compare every output.
  task automatic step();
    bit done_old;
    @(posedge clk);
    done_old = m_done;
    if (rst) begin
      m_reqq = 3'd0;
      m_tgt  = 3'd0;
      m_e    = CAP;
      m_irq  = 1'b0;
    end else begin
      m_irq = done_old ? 1'b1 : (irq_clr ? 1'b0 : m_irq);
      if (m_reqq != m_tgt) begin
        m_tgt = m_reqq;
        m_e   = 0;
      end else if (m_e < CAP) begin
        m_e++;
      end
      m_reqq = (class_req > 3'd5) ? 3'd5 : class_req;
    end
    m_done = !rst && (((m_tgt == 3'd0) && (m_e == D)) ||
                      ((m_tgt != 3'd0) && (m_e == D + S)));
    #1;
    if (done === 1'b1) done_cnt++;
    check("cycle", 16'(act_vec()), 16'(model_vec()));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic vec_t mk(input logic r, input logic [2:0] q, input logic p,
                              input int h, input logic [11:0] e);
    vec_t v;
    v.rst = r; v.req = q; v.pull = p; v.clr = 1'b0; v.hold = h; v.exp = e;
    return v;
  endfunction

  vec_t tbl[10];

  initial begin
    rst = 1'b1; class_req = 3'd0; core_pull = 1'b0; irq_clr = 1'b0;

    //               rst  req  pull hold  {rstn,    act, pull,oe, busy,done}
    tbl[0] = mk(1'b1, 3'd0, 1'b0,  2, {5'b00000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl[1] = mk(1'b0, 3'd0, 1'b0, 20, {5'b00000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl[2] = mk(1'b0, 3'd3, 1'b1,  2, {5'b00000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0});
    tbl[3] = mk(1'b0, 3'd3, 1'b1,  8, {5'b00100, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0});
    tbl[4] = mk(1'b0, 3'd3, 1'b1,  3, {5'b00100, 3'd3, 1'b1, 1'b1, 1'b0, 1'b1});
    tbl[5] = mk(1'b0, 3'd3, 1'b0,  1, {5'b00100, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl[6] = mk(1'b0, 3'd5, 1'b1,  2, {5'b00000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0});
    tbl[7] = mk(1'b0, 3'd5, 1'b1, 11, {5'b10000, 3'd5, 1'b1, 1'b1, 1'b0, 1'b1});
    tbl[8] = mk(1'b0, 3'd7, 1'b1,  5, {5'b10000, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl[9] = mk(1'b0, 3'd0, 1'b0, 10, {5'b00000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1});

    for (int i = 0; i < 10; i++) begin
      rst = tbl[i].rst; class_req = tbl[i].req; core_pull = tbl[i].pull;
      irq_clr = tbl[i].clr;
      if (i == 1) done_cnt = 0;
      steps(tbl[i].hold);
      check($sformatf("vec[%0d]", i), 16'(act_vec() >> 1), 16'(tbl[i].exp));
      if (i == 1) check("idle_no_done", 16'(done_cnt), 16'd0);
    end

    // Abort on disconnect cycle 5: restart, one completion only.
    steps(1);
    done_cnt = 0;
    core_pull = 1'b1;
    class_req = 3'd2; steps(2);
    check("restart_busy", 16'(busy), 16'd1);
    steps(4);
    class_req = 3'd4; steps(2);
    steps(7);
    check("restart_still_disc", 16'({core_rstn, busy}), 16'({5'b00000, 1'b1}));
    steps(3);
    check("restart_settle", 16'({core_rstn, busy, done}), 16'({5'b01000, 1'b1, 1'b0}));
    steps(1);
    check("restart_active", 16'({core_rstn, active_class, done}), 16'({5'b01000, 3'd4, 1'b1}));
    steps(3);
    check("restart_one_done", 16'(done_cnt), 16'd1);

    // Reset during SETTLE, then a fresh full switch.
    class_req = 3'd1; steps(2 + D);
    check("pre_rst_settle", 16'(core_rstn), 16'b00001);
    rst = 1'b1; steps(1);
    check("rst_in_settle", 16'(act_vec()), 16'd0);
    rst = 1'b0; steps(2);
    check("post_rst_busy", 16'({busy, core_rstn}), 16'({1'b1, 5'b00000}));
    steps(D + S);
    check("post_rst_active", 16'({core_rstn, done}), 16'({5'b00001, 1'b1}));

`ifdef USB_CLASS_SWITCH_IRQ_EN
    steps(3);
    check("irq_sticky", 16'(irq), 16'd1);
    irq_clr = 1'b1; steps(1); irq_clr = 1'b0;
    check("irq_cleared", 16'(irq), 16'd0);
    class_req = 3'd2; steps(2 + D + S);
    check("irq_done_pulse", 16'(done), 16'd1);
    irq_clr = 1'b1; steps(1); irq_clr = 1'b0;
    check("irq_set_wins", 16'(irq), 16'd1);
`endif

    // Random traffic, checked every cycle by the model.
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 3) == 0) class_req = 3'($urandom_range(0, 7));
      core_pull = 1'($urandom);
      irq_clr   = ($urandom_range(0, 4) == 0);
      rst       = ($urandom_range(0, 40) == 0);
      steps($urandom_range(1, 14));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/usb_class_switch_ctrl.md
Name: usb_class_switch_ctrl

Overview:
Sequencer that owns switching of the shared USB PHY lines between the device-class cores (audio, camera, disk, keyboard, serial).
- On a class-select change it forces a bus disconnect: D+ pull-up off, PHY drive off, all cores held in reset, for a fixed time so the host detects detach.
- It then releases only the newly selected core, waits a settle time, and hands it the pull-up.
- Sits between the CCR register field and the per-core reset/pull-up/output-enable muxing in the USB top.

Parameters:
- NUM_CLASSES, 5, number of class cores; codes 1..NUM_CLASSES, 0 = none.
- DISC_CYCLES, 6000000, clocks spent in DISCONNECT (100 ms at 60 MHz); must be >= 1.
- SETTLE_CYCLES, 64, clocks a released core runs before its pull-up is honoured; must be >= 1.
- CNT_W, 24, down-counter width; must hold max(DISC_CYCLES, SETTLE_CYCLES)-1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- class_req_i  in  3  requested class from CCR; values > NUM_CLASSES saturate to NUM_CLASSES.
- core_pull_i  in  1  pull-up request of the currently selected core.
- core_rstn_o  out  NUM_CLASSES  one-hot active-low-reset release; bit k-1 is class k.
- active_class_o  out  3  class whose core is released; 0 when none.
- usb_dp_pull_o  out  1  gated D+ pull-up to PHY.
- phy_oe_en_o  out  1  permits the selected core to drive dp/dn.
- busy_o  out  1  switch in progress (DISCONNECT or SETTLE).
- done_o  out  1  one-cycle pulse when a switch completes.
- irq_o  out  1  see Optional Feature.
- irq_clr_i  in  1  see Optional Feature.

Behaviour:
- Reset value of every output is 0: state OFF, target 0, counter 0, all core_rstn_o bits 0.
- class_req_i is registered into req_q. All decisions use req_q, so a change shows on outputs 2 cycles after it appears on the input.
- States:
  - OFF: no core released, pull 0, oe 0.
  - DISCONNECT: rstn all 0, pull 0, oe 0, busy 1.
  - SETTLE: rstn[target]=1, pull 0, oe 1, busy 1.
  - ACTIVE: rstn[target]=1, pull=core_pull_i, oe 1.
- Any state, req_q != target: target<=req_q, counter<=DISC_CYCLES-1, go DISCONNECT. This takes priority over every other transition.
- DISCONNECT, counter==0, no new request: target==0 -> OFF; else counter<=SETTLE_CYCLES-1, go SETTLE.
- SETTLE, counter==0: go ACTIVE.
- Otherwise the counter decrements by 1 per cycle in DISCONNECT and SETTLE, with no wrap; it holds in OFF and ACTIVE.
- DISCONNECT lasts exactly DISC_CYCLES cycles; SETTLE lasts exactly SETTLE_CYCLES cycles.
- done_o pulses for 1 cycle on the cycle after entering ACTIVE, or entering OFF from DISCONNECT.
- active_class_o = target in SETTLE/ACTIVE, else 0.
- Request change mid-DISCONNECT or mid-SETTLE: relatch target and restart the full DISC_CYCLES. No done_o for the aborted switch.
- req_q equal to target: no action, including a repeat write of the same class.
- Reset mid-switch returns to OFF in one cycle. A nonzero class_req_i afterwards starts a fresh full disconnect.
- usb_dp_pull_o is combinational from the state register and core_pull_i only; the core output is not registered.

Optional Feature:
- Macro USB_CLASS_SWITCH_IRQ_EN.
- Defined: irq_o is a sticky flag, set on done_o and cleared by irq_clr_i. If set and clear occur in the same cycle, set wins. Reset value is 0.
- Undefined: irq_o is tied 0, irq_clr_i is ignored, and no flop is inferred.

Decomposition:
- Shared package usb_pkg:
  - Class code constants: AUDIO=1, CAMERA=2, DISK=3, KEYBOARD=4, SERIAL=5, NONE=0.
  - Switch FSM state encoding: OFF/DISCONNECT/SETTLE/ACTIVE.
  - Also consumed by the USB top's mux and status logic.
- One sub-module, usb_sw_timer: loadable CNT_W down-counter with load, load value, enable and zero flag.

Test Plan:
Run with DISC_CYCLES=8, SETTLE_CYCLES=3.
- Reset, class_req_i=0 for 20 cycles -> all outputs 0, done_o never pulses.
- class_req_i 0->3 -> busy_o rises 2 cycles later; core_rstn_o=5'b00000 for 8 cycles, then 5'b00100 with pull 0 for 3 cycles; then usb_dp_pull_o follows core_pull_i=1; done_o pulses once; active_class_o=3.
- In ACTIVE class 3, request 5 -> pull drops and core_rstn_o=0 for 8 cycles; then 5'b10000; done_o pulses once.
- Request 2, then 4 on DISCONNECT cycle 5 -> disconnect restarts for a full 8 cycles; final core_rstn_o=5'b01000; exactly one done_o pulse.
- class_req_i=7 -> saturates to 5; rewriting 5 while ACTIVE causes no disconnect.
- rst_i asserted during SETTLE -> next cycle all outputs 0. With USB_CLASS_SWITCH_IRQ_EN: irq_o set after done_o, held until irq_clr_i; set and clear in the same cycle leave irq_o=1.
